// File: rtl/util_pkg.sv
// Shared types and elaboration helpers for the util block family.
package util_pkg;

    // Deserializer word-alignment state; one bit is enough for two states.
    typedef enum logic {
        HUNT     = 1'b0,
        ASSEMBLE = 1'b1
    } s2p_state_e;

    // Number of bits needed to hold values 0..n-1 (at least 1).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold at full scale instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Bit-serial to word-parallel deserializer with start-of-word alignment.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   HUNT     | unaligned; valid bits are dropped until a din_sof arrives
//   ASSEMBLE | aligned; bits are shifted in, a word completes every WIDTH
module serial_to_parallel
    import util_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din,
    input  logic             din_vld,
    input  logic             din_sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             locked,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int               CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    s2p_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             sync_err_q, sync_err_d;

    // Insert one bit at the side chosen by MSB_FIRST so the first bit of a
    // word ends up at dout[WIDTH-1] (MSB first) or dout[0] (LSB first).
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] a,
                                                  input logic             b);
        if (MSB_FIRST) begin
            return {a[WIDTH-2:0], b};
        end else begin
            return {b, a[WIDTH-1:1]};
        end
    endfunction

    // Next-state, accumulator, bit count and output pulses.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        sync_err_d = 1'b0;

        if (clr) begin
            state_d = HUNT;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (din_vld) begin
            case (state_q)
                HUNT: begin
                    if (din_sof) begin
                        state_d = ASSEMBLE;
                        cnt_d   = CNT_W'(1);
                        acc_d   = shift_in('0, din);
                    end
                end
                ASSEMBLE: begin
                    if (din_sof) begin
                        // A marker mid-word means we were misaligned: the
                        // partial word is dropped and the marker restarts.
                        sync_err_d = (cnt_q != '0);
                        cnt_d      = CNT_W'(1);
                        acc_d      = shift_in('0, din);
                    end else if (cnt_q == LAST_IDX) begin
                        acc_d      = shift_in(acc_q, din);
                        dout_d     = shift_in(acc_q, din);
                        dout_vld_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        acc_d = shift_in(acc_q, din);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HUNT;
            cnt_q      <= '0;
            acc_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            sync_err_q <= sync_err_d;
        end
    end

    // err_cnt steps on the same edge that raises sync_err.
    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst),
        .inc_i(sync_err_d),
        .cnt_o(err_cnt)
    );

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign locked   = (state_q == ASSEMBLE);
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (MSB-first and LSB-first instances).
module tb_serial_to_parallel;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       din = 1'b0;
    logic       din_vld = 1'b0;
    logic       din_sof = 1'b0;

    logic [7:0] dout, lsb_dout;
    logic       dout_vld, locked, sync_err;
    logic       lsb_vld, lsb_locked, lsb_serr;
    logic [7:0] err_cnt, lsb_err;

    int         checks = 0;
    int         errors = 0;
    int         vld_cnt = 0;
    int         serr_cnt = 0;
    int         vb;
    logic [7:0] words[$];
    int         gaps[8] = '{0, 2, 1, 3, 0, 1, 2, 3};

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1), .ERR_W(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .din     (din),
        .din_vld (din_vld),
        .din_sof (din_sof),
        .dout    (dout),
        .dout_vld(dout_vld),
        .locked  (locked),
        .sync_err(sync_err),
        .err_cnt (err_cnt)
    );

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0), .ERR_W(8)) u_lsb (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .din     (din),
        .din_vld (din_vld),
        .din_sof (din_sof),
        .dout    (lsb_dout),
        .dout_vld(lsb_vld),
        .locked  (lsb_locked),
        .sync_err(lsb_serr),
        .err_cnt (lsb_err)
    );

    // Pulse monitor for the MSB-first instance.
    always @(negedge clk) begin
        if (dout_vld) begin
            words.push_back(dout);
            vld_cnt++;
        end
        if (sync_err) serr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus, applied at a falling edge.
    task automatic cyc(input logic v, input logic s, input logic d);
        din_vld = v;
        din_sof = s;
        din     = d;
        @(negedge clk);
        din_vld = 1'b0;
        din_sof = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit sof, input bit use_gaps);
        logic [7:0] wv;
        wv = w;
        for (int i = 7; i >= 0; i--) begin
            if (use_gaps) repeat (gaps[i]) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b1, sof && (i == 7), wv[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w;

        // Reset values before any clock edge.
        #2;
        chk("rst_dout", dout, 8'h00);
        chk("rst_vld", dout_vld, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_serr", sync_err, 1'b0);
        chk("rst_errcnt", err_cnt, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: single aligned word 0xA5.
        w = 8'hA5;
        cyc(1'b1, 1'b1, w[7]);
        chk("t1_locked", locked, 1'b1);
        for (int i = 6; i >= 1; i--) cyc(1'b1, 1'b0, w[i]);
        chk("t1_no_early_vld", dout_vld, 1'b0);
        cyc(1'b1, 1'b0, w[0]);
        chk("t1_vld", dout_vld, 1'b1);
        chk("t1_dout", dout, 8'hA5);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_vld_one_cycle", dout_vld, 1'b0);
        chk("t1_dout_hold", dout, 8'hA5);

        // 2: back-to-back words with gaps, sof on the first only.
        #1;
        vb = vld_cnt;
        send_word(8'h3C, 1'b1, 1'b1);
        send_word(8'hF0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_vld_pulses", vld_cnt - vb, 2);
        chk("t2_word0", words[vb], 8'h3C);
        chk("t2_word1", words[vb+1], 8'hF0);
        chk("t2_no_serr", serr_cnt, 0);

        // 3: misaligned sof followed by 0x81, repeated to saturate err_cnt.
        vb = vld_cnt;
        for (int k = 0; k < 300; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            repeat (3) cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b1);
            if (k == 0) begin
                chk("t3_serr", sync_err, 1'b1);
                chk("t3_errcnt1", err_cnt, 8'd1);
            end
            for (int i = 0; i < 6; i++) begin
                cyc(1'b1, 1'b0, 1'b0);
                if (k == 0 && i == 0) chk("t3_serr_pulse", sync_err, 1'b0);
            end
            cyc(1'b1, 1'b0, 1'b1);
            if (k == 0) begin
                chk("t3_vld", dout_vld, 1'b1);
                chk("t3_dout", dout, 8'h81);
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        #1;
        chk("t3_errcnt_sat", err_cnt, 8'd255);
        chk("t3_serr_pulses", serr_cnt, 300);
        chk("t3_vld_pulses", vld_cnt - vb, 300);

        // 4: no sof after reset, then clr mid-word.
        do_reset();
        chk("t4_errcnt_rst", err_cnt, 8'd0);
        #1;
        vb = vld_cnt;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, (i % 3) == 0);
        chk("t4_hunt_locked", locked, 1'b0);
        chk("t4_hunt_dout", dout, 8'h00);
        #1;
        chk("t4_hunt_no_vld", vld_cnt - vb, 0);
        send_word(8'h5A, 1'b1, 1'b0);
        chk("t4_word", dout, 8'h5A);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("t4_errcnt_pre_clr", err_cnt, 8'd1);
        clr = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        clr = 1'b0;
        chk("t4_clr_locked", locked, 1'b0);
        chk("t4_clr_vld", dout_vld, 1'b0);
        chk("t4_clr_dout", dout, 8'h5A);
        chk("t4_clr_errcnt", err_cnt, 8'd1);
        send_word(8'hFF, 1'b0, 1'b0);
        chk("t4_post_clr_locked", locked, 1'b0);
        #1;
        chk("t4_post_clr_vld", vld_cnt - vb, 1);

        // 5: async reset mid-word.
        cyc(1'b1, 1'b1, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        chk("t5_locked_before", locked, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_dout", dout, 8'h00);
        chk("t5_rst_locked", locked, 1'b0);
        chk("t5_rst_errcnt", err_cnt, 8'd0);
        chk("t5_rst_vld", dout_vld, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vb = vld_cnt;
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t5_relock", locked, 1'b0);
        #1;
        chk("t5_no_vld", vld_cnt - vb, 0);

        // 6: LSB-first ordering.
        do_reset();
        send_word(8'hA5, 1'b1, 1'b0);
        chk("t6_lsb_vld", lsb_vld, 1'b1);
        chk("t6_lsb_dout", lsb_dout, 8'hA5);
        send_word(8'hC0, 1'b0, 1'b0);
        chk("t6_lsb_dout2", lsb_dout, 8'h03);
        chk("t6_msb_dout2", dout, 8'hC0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_lsb_vld_off", lsb_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
